// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and frame constants (receiver and transmitter)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4,
        ST_BREAK   = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_8n1
// Description : Oversampling 8N1 UART receiver, one-cycle valid/frame-error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_rtl,
    input  logic                 i_rx_serial,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_data_valid,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_busy
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_last     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_last_bit = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q,   state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 err_q,     err_d;
    logic                 stop_ok;
    logic                 stop_bad;

    // Reset to idle-high so a reset never looks like a start edge on an idle line
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clock),
        .rst     (reset_rtl),
        .i_async (i_rx_serial),
        .o_sync  (rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset_rtl) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (clk_cnt_q == c_half) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == c_last) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == c_last_bit) state_d = ST_STOP;
                    else                         bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == c_last) begin
                    clk_cnt_d = '0;
                    stop_ok   = rx_s;
                    stop_bad  = !rx_s;
                    state_d   = rx_s ? ST_CLEANUP : ST_BREAK;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_CLEANUP: state_d = ST_IDLE;
            // Wait out a held-low line so it is not decoded as repeated 0x00 frames
            ST_BREAK:   if (rx_s) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d    = stop_ok ? shift_q : data_q;
        valid_d   = stop_ok;
        err_d     = stop_bad;
        o_rx_busy = (state_q != ST_IDLE);
    end

    assign o_rx_data       = data_q;
    assign o_rx_data_valid = valid_q;
    assign o_rx_frame_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_8n1
// Description : Self-checking bench for uart_rx_8n1 (16 and 434 clocks/bit)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_8n1;

    localparam int CPB   = 16;
    localparam int CPB_P = 434;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_p;
    logic [7:0] rx_data,  rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       rx_err,   rx_err_p;
    logic       rx_busy,  rx_busy_p;

    always #5 clk = ~clk;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clock           (clk),
        .reset_rtl       (rst),
        .i_rx_serial     (rx),
        .o_rx_data       (rx_data),
        .o_rx_data_valid (rx_valid),
        .o_rx_frame_err  (rx_err),
        .o_rx_busy       (rx_busy)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB_P)) dut_p (
        .clock           (clk),
        .reset_rtl       (rst),
        .i_rx_serial     (rx_p),
        .o_rx_data       (rx_data_p),
        .o_rx_data_valid (rx_valid_p),
        .o_rx_frame_err  (rx_err_p),
        .o_rx_busy       (rx_busy_p)
    );

    typedef struct {
        logic [7:0] data;
        logic       is_err;
        int         delta;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         hold_low;
        int         delta;
    } vec_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         rel;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         last_valid_cyc = 0;
    logic [7:0] model_data = 8'h00;
    int         p_cnt = 0;
    int         p_valid_cyc = 0;
    logic [7:0] p_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller must be aligned 1 time unit after a rising edge
    task automatic send_frame(input int cpb, input bit sel, input logic [7:0] d,
                              input logic stop, input bit push, input int delta);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        if (push) sb_q.push_back('{d, ~stop, delta});
        for (int i = 0; i < 10; i++) begin
            if (sel) rx_p = bits[i];
            else     rx   = bits[i];
            if (i == 0) start_cyc = cyc + 1;
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer for the 16 clocks/bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid || rx_err) check("exclusive", {31'd0, rx_valid & rx_err}, 32'd0);
        if (rx_valid) begin
            valid_cnt++;
            check("valid_expected", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("valid_kind", {31'd0, e.is_err}, 32'd0);
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                if (e.delta > 0) check("frame_spacing", cyc - last_valid_cyc, e.delta);
                last_valid_cyc = cyc;
                model_data     = e.data;
            end
        end
        if (rx_err) begin
            err_cnt++;
            check("err_expected", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("err_kind", {31'd0, e.is_err}, 32'd1);
                check("data_held", {24'd0, rx_data}, {24'd0, model_data});
            end
        end
        if (rx_valid_p) begin
            p_cnt++;
            p_valid_cyc = cyc;
            p_data      = rx_data_p;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[7];
        int         vc;
        int         ec;
        logic [9:0] bits;

        vecs[0] = '{8'h00, 1'b1, 0,  0,   0};
        vecs[1] = '{8'hFF, 1'b1, 0,  0,   160};
        vecs[2] = '{8'h5A, 1'b1, 20, 0,   160};
        vecs[3] = '{8'h3C, 1'b0, 10, 100, 0};
        vecs[4] = '{8'h81, 1'b1, 10, 0,   0};
        vecs[5] = '{8'h80, 1'b1, 0,  0,   0};
        vecs[6] = '{8'h01, 1'b1, 10, 0,   160};

        rst  = 1'b1;
        rx   = 1'b1;
        rx_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",    {24'd0, rx_data},  32'd0);
        check("rst_valid",   {31'd0, rx_valid}, 32'd0);
        check("rst_err",     {31'd0, rx_err},   32'd0);
        check("rst_busy",    {31'd0, rx_busy},  32'd0);
        check("rst_busy_p",  {31'd0, rx_busy_p}, 32'd0);
        check("rst_data_p",  {24'd0, rx_data_p}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single frame with cycle-exact milestones
        fork
            send_frame(CPB, 1'b0, 8'hA5, 1'b1, 1'b1, 0);
            begin
                #2;
                for (int n = 0; n < 160; n++) begin
                    @(negedge clk);
                    rel = cyc - start_cyc;
                    if (rel == 1)   check("busy_c1",   {31'd0, rx_busy},  32'd0);
                    if (rel == 2)   check("busy_c2",   {31'd0, rx_busy},  32'd1);
                    if (rel == 153) check("valid_c153", {31'd0, rx_valid}, 32'd0);
                    if (rel == 154) check("valid_c154", {31'd0, rx_valid}, 32'd1);
                    if (rel == 154) check("busy_c154", {31'd0, rx_busy},  32'd1);
                    if (rel == 155) check("busy_c155", {31'd0, rx_busy},  32'd0);
                end
            end
        join

        // Back-to-back frames, framing error with break, recovery
        for (int i = 0; i < 7; i++) begin
            ec = err_cnt;
            send_frame(CPB, 1'b0, vecs[i].data, vecs[i].stop, 1'b1, vecs[i].delta);
            if (vecs[i].hold_low > 0) begin
                repeat (vecs[i].hold_low) @(posedge clk);
                #1;
                check("break_hold_busy", {31'd0, rx_busy}, 32'd1);
                check("err_pulse_once", err_cnt, ec + 1);
                rx = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                check("break_exit", {31'd0, rx_busy}, 32'd0);
            end
            repeat (vecs[i].gap) @(posedge clk);
            #1;
        end
        for (int w = 0; w < 400 && sb_q.size() > 0; w++) @(posedge clk);
        #1;
        check("sb_drained_table", sb_q.size(), 32'd0);

        // Glitch: 4 clocks low is rejected at the start-bit centre
        vc = valid_cnt;
        ec = err_cnt;
        rx = 1'b0;
        start_cyc = cyc + 1;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("glitch_idle", {31'd0, rx_busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("glitch_no_valid", valid_cnt, vc);
        check("glitch_no_err",   err_cnt,   ec);

        // Reset during data bit 4 of 0xC3; the host abandons the frame
        vc   = valid_cnt;
        bits = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = bits[4];
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_data = 8'h00;
        check("midrst_data",  {24'd0, rx_data},  32'd0);
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_err",   {31'd0, rx_err},   32'd0);
        check("midrst_busy",  {31'd0, rx_busy},  32'd0);
        repeat (200) @(posedge clk);
        #1;
        check("midrst_no_pulse", valid_cnt, vc);
        send_frame(CPB, 1'b0, 8'h7E, 1'b1, 1'b1, 0);
        for (int w = 0; w < 100 && sb_q.size() > 0; w++) @(posedge clk);
        #1;
        check("sb_drained_rst", sb_q.size(), 32'd0);

        // Production divisor
        send_frame(CPB_P, 1'b1, 8'h3C, 1'b1, 1'b0, 0);
        repeat (20) @(posedge clk);
        #1;
        check("prod_count", p_cnt, 32'd1);
        check("prod_data",  {24'd0, p_data}, 32'h3C);
        check("prod_cycle", p_valid_cyc - start_cyc, 32'd4125);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
